// File: rtl/joy_scan_pkg.sv
// joy_scan_pkg
//   Shared types and constants for the joystick shift-register scan sequencer.
//   - joy_state_e : sequencer state encoding (IDLE, LOAD, SHIFT, GAP)
//   - default parameter values used by joy_scan_sequencer
//   - FRAME_CNT_W : width of the published-frame counter
//   - cnt_w()     : register width able to hold the values 0..n-1
package joy_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } joy_state_e;

  localparam int JOY_CLK_DIV_DEF     = 16;
  localparam int JOY_CHAIN_BITS_DEF  = 16;
  localparam int JOY_LOAD_CYCLES_DEF = 1;
  localparam int JOY_SCAN_GAP_DEF    = 2;
  localparam int FRAME_CNT_W         = 8;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/joy_scan_clkdiv.sv
// joy_scan_clkdiv
//   Shift-period divider for the joystick scan sequencer. Counts 0..CLK_DIV-1
//   and is forced to 0 while hold_i is high (sequencer idle).
// Ports
//   clk_i      in   system clock
//   rst_i      in   synchronous reset, active-high
//   hold_i     in   hold the counter at 0
//   div_cnt_o  out  current divider phase
//   tick_o     out  last cycle of a shift period (div_cnt == CLK_DIV-1)
//   mid_o      out  sample point, half a period in (div_cnt == CLK_DIV/2-1)
module joy_scan_clkdiv #(
  parameter int CLK_DIV = 16,
  parameter int DIV_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  output logic [DIV_W-1:0] div_cnt_o,
  output logic             tick_o,
  output logic             mid_o
);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;

  assign w_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || hold_i) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign div_cnt_o = r_div_cnt;
  assign tick_o    = w_tick;
  assign mid_o     = (r_div_cnt == DIV_W'(CLK_DIV / 2 - 1));

endmodule

// File: rtl/joy_scan_sequencer.sv
// joy_scan_sequencer
//   Drives a 74HC165-style joystick chain: active-low parallel load, shift
//   clock, serial capture of CHAIN_BITS bits per scan, and hand-off of each
//   completed frame over a valid/ready handshake.
// Ports
//   clk_i          in   system clock
//   rst_i          in   synchronous reset, active-high
//   enable_i       in   run continuous scanning (checked at frame boundaries)
//   joy_data_i     in   serial data from the chain (buttons active-low)
//   joy_clk_o      out  shift clock to the chain
//   joy_load_o     out  parallel load, active-low
//   frame_o        out  last published frame, first-shifted bit at MSB
//   frame_valid_o  out  frame_o holds an unconsumed frame
//   frame_ready_i  in   consumer accepts frame_o this cycle
//   overrun_o      out  1-cycle pulse: an unconsumed frame was overwritten
//   frame_count_o  out  published-frame counter (wraps)
//   busy_o         out  sequencer not idle
// Build option
//   JOY_SCAN_DEBOUNCE_EN : publish a scan only when it matches the previous
//                          raw scan; otherwise every completed scan is published.
//
// state | meaning
// IDLE  | chain quiet, divider held at 0, waiting for enable_i
// LOAD  | joy_load_o low for LOAD_CYCLES shift periods
// SHIFT | CHAIN_BITS shift periods; sample at mid, rising joy_clk_o after it
// GAP   | SCAN_GAP quiet shift periods before the next scan or IDLE
module joy_scan_sequencer
  import joy_scan_pkg::*;
#(
  parameter int CLK_DIV     = JOY_CLK_DIV_DEF,
  parameter int CHAIN_BITS  = JOY_CHAIN_BITS_DEF,
  parameter int LOAD_CYCLES = JOY_LOAD_CYCLES_DEF,
  parameter int SCAN_GAP    = JOY_SCAN_GAP_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   joy_data_i,
  output logic                   joy_clk_o,
  output logic                   joy_load_o,
  output logic [CHAIN_BITS-1:0]  frame_o,
  output logic                   frame_valid_o,
  input  logic                   frame_ready_i,
  output logic                   overrun_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o,
  output logic                   busy_o
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int TMAX_A = (LOAD_CYCLES > CHAIN_BITS) ? LOAD_CYCLES : CHAIN_BITS;
  localparam int TMAX   = (TMAX_A > SCAN_GAP) ? TMAX_A : SCAN_GAP;
  localparam int TCNT_W = cnt_w(TMAX);

  joy_state_e             r_state;
  joy_state_e             w_state_nxt;
  logic [DIV_W-1:0]       w_div_cnt;
  logic                   w_tick;
  logic                   w_mid;
  logic [TCNT_W-1:0]      r_tick_cnt;
  logic                   w_last;
  logic                   w_joy_clk;
  logic                   w_joy_load;
  logic [CHAIN_BITS-1:0]  r_sr;
  logic                   r_pub_pend;
  logic                   w_publish;
  logic [CHAIN_BITS-1:0]  r_frame;
  logic                   r_frame_valid;
  logic                   r_overrun;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  joy_scan_clkdiv #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_clkdiv (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .hold_i    (r_state == IDLE),
    .div_cnt_o (w_div_cnt),
    .tick_o    (w_tick),
    .mid_o     (w_mid)
  );

  // Per-state length in shift periods, minus one, for the down-counter.
  function automatic logic [TCNT_W-1:0] reload(input joy_state_e st);
    case (st)
      SHIFT:   return TCNT_W'(CHAIN_BITS - 1);
      GAP:     return (SCAN_GAP > 0) ? TCNT_W'(SCAN_GAP - 1) : '0;
      default: return TCNT_W'(LOAD_CYCLES - 1);
    endcase
  endfunction

  // Last tick of the current state.
  assign w_last = (r_state != IDLE) && w_tick && (r_tick_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_joy_load  = 1'b1;
    w_joy_clk   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_joy_load = 1'b0;
        if (w_last) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        // High during the second half of the period so the sample at mid
        // always precedes the rising edge that moves the chain on.
        w_joy_clk = (w_div_cnt >= DIV_W'(CLK_DIV / 2));
        if (w_last) begin
          if (SCAN_GAP > 0)  w_state_nxt = GAP;
          else if (enable_i) w_state_nxt = LOAD;
          else               w_state_nxt = IDLE;
        end
      end
      GAP: begin
        if (w_last) w_state_nxt = enable_i ? LOAD : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Tick down-counter: reloaded while idle and on every state exit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tick_cnt <= reload(IDLE);
    end else if (r_state == IDLE || w_last) begin
      r_tick_cnt <= reload(w_state_nxt);
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sr       <= '1;
      r_pub_pend <= 1'b0;
    end else begin
      if (r_state == SHIFT && w_mid) begin
        r_sr <= {r_sr[CHAIN_BITS-2:0], joy_data_i};
      end
      // The shift register is complete after the last SHIFT tick; hand it
      // over on the following cycle.
      r_pub_pend <= (r_state == SHIFT) && w_last;
    end
  end

`ifdef JOY_SCAN_DEBOUNCE_EN
  logic [CHAIN_BITS-1:0] r_raw_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_raw_prev <= '1;
    end else if (r_pub_pend) begin
      r_raw_prev <= r_sr;
    end
  end

  assign w_publish = r_pub_pend && (r_sr == r_raw_prev);
`else
  assign w_publish = r_pub_pend;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame       <= '1;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_overrun <= 1'b0;
      if (w_publish) begin
        // A same-cycle transfer consumes the old frame, so no overrun then.
        r_frame       <= r_sr;
        r_frame_cnt   <= r_frame_cnt + 1'b1;
        r_frame_valid <= 1'b1;
        r_overrun     <= r_frame_valid & ~frame_ready_i;
      end else if (r_frame_valid && frame_ready_i) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign joy_clk_o     = w_joy_clk;
  assign joy_load_o    = w_joy_load;
  assign frame_o       = r_frame;
  assign frame_valid_o = r_frame_valid;
  assign overrun_o     = r_overrun;
  assign frame_count_o = r_frame_cnt;
  assign busy_o        = (r_state != IDLE);

endmodule
